// File: rtl/risc16_boot_loader_pkg.sv
// Shared definitions for the RiSC-16 boot loader: word width and loader state encoding.
package risc16_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CSUM_HI,
        CSUM_LO,
        RUN,
        ERR
    } state_t;

endpackage

// File: rtl/risc16_boot_loader.sv
// Receives a length-prefixed, checksummed program image byte by byte, writes it to imem
// and releases the RiSC-16 core only when the additive checksum matches.
module risc16_boot_loader
    import risc16_pkg::*;
#(
    parameter int IMEM_AW = 10
) (
    input  logic               clk0,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    input  logic               restart,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [15:0]        imem_wdata,
    output logic               core_hold,
    output logic               boot_done,
    output logic               boot_error
);

    // Memory capacity as a WORD_W+1 bit value so a full 2**IMEM_AW length compares cleanly.
    localparam logic [WORD_W:0] CAP = {{(WORD_W - IMEM_AW){1'b0}}, 1'b1, {IMEM_AW{1'b0}}};

    state_t              state, state_nx;
    logic [7:0]          hi_byte;
    logic [WORD_W-1:0]   rx_word;
    logic [WORD_W:0]     n_ext;
    logic [IMEM_AW:0]    len;
    logic [IMEM_AW:0]    cnt;
    logic [IMEM_AW:0]    cnt_inc;
    logic [WORD_W-1:0]   sum;
    logic                accept;
    logic                reload;

    assign rx_word = {hi_byte, rx_data};
    assign n_ext   = {1'b0, rx_word};
    assign cnt_inc = cnt + 1'b1;
    assign accept  = rx_valid && rx_ready;
    assign reload  = restart && ((state == RUN) || (state == ERR));

    assign rx_ready   = (state != RUN) && (state != ERR);
    assign core_hold  = (state != RUN);
    assign boot_done  = (state == RUN);
    assign boot_error = (state == ERR);

    always_ff @(posedge clk0) begin
        if (reset) state <= LEN_HI;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LEN_HI:  if (accept) state_nx = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if (n_ext > CAP)       state_nx = ERR;
                    else if (rx_word == '0) state_nx = CSUM_HI;
                    else                    state_nx = DATA_HI;
                end
            end
            DATA_HI: if (accept) state_nx = DATA_LO;
            DATA_LO: if (accept) state_nx = (cnt_inc < len) ? DATA_HI : CSUM_HI;
            CSUM_HI: if (accept) state_nx = CSUM_LO;
            CSUM_LO: if (accept) state_nx = (rx_word == sum) ? RUN : ERR;
            RUN:     if (restart) state_nx = LEN_HI;
            ERR:     if (restart) state_nx = LEN_HI;
            default: state_nx = LEN_HI;
        endcase
    end

    // Word write, word counter and running sum all advance on the low-byte accept.
    always_ff @(posedge clk0) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cnt        <= '0;
            sum        <= '0;
        end else begin
            imem_we <= 1'b0;
            if (accept && (state == DATA_LO)) begin
                imem_we    <= 1'b1;
                imem_addr  <= cnt[IMEM_AW-1:0];
                imem_wdata <= rx_word;
                cnt        <= cnt_inc;
                sum        <= sum + rx_word;
            end
            if (reload) begin
                cnt <= '0;
                sum <= '0;
            end
        end
    end

    // Byte assembly and the latched length are pure data; state guarantees they are refilled before use.
    always_ff @(posedge clk0) begin
        if (accept && ((state == LEN_HI) || (state == DATA_HI) || (state == CSUM_HI)))
            hi_byte <= rx_data;
        if (accept && (state == LEN_LO))
            len <= n_ext[IMEM_AW:0];
    end

endmodule

// File: tb/tb_risc16_boot_loader.sv
// Scoreboard bench for risc16_boot_loader: expected imem writes are queued as bytes are sent.
module tb_risc16_boot_loader;

    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic          clk0 = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          restart = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          core_hold;
    logic          boot_done;
    logic          boot_error;

    typedef struct {
        int          addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] img[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    risc16_boot_loader #(.IMEM_AW(AW)) dut (
        .clk0      (clk0),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .restart   (restart),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_hold (core_hold),
        .boot_done (boot_done),
        .boot_error(boot_error)
    );

    always #5 clk0 = ~clk0;

    always @(posedge clk0) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk0) begin : monitor
        wr_t e;
        if (imem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("we_addr", 32'(imem_addr), 32'(e.addr));
                check("we_data", 32'(imem_wdata), 32'(e.data));
                check("we_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 32'(rx_ready), 1);
        check({tag, "_hold"},  32'(core_hold), 1);
        check({tag, "_done"},  32'(boot_done), 0);
        check({tag, "_error"}, 32'(boot_error), 0);
    endtask

    task automatic apply_reset();
        rx_valid = 1'b0;
        restart  = 1'b0;
        reset    = 1'b1;
        @(posedge clk0);
        #1;
        reset = 1'b0;
        check_idle_outputs("rst");
        check("rst_we",    32'(imem_we), 0);
        check("rst_addr",  32'(imem_addr), 0);
        check("rst_wdata", 32'(imem_wdata), 0);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk0);
        #1;
        restart = 1'b0;
        check_idle_outputs("restart");
    endtask

    // Optional random idle cycles, with stray restart pulses that a receiving loader must ignore.
    task automatic send_byte(input logic [7:0] b, input bit stall);
        if (stall) begin
            repeat ($urandom_range(0, 2)) begin
                rx_valid = 1'b0;
                restart  = 1'($urandom_range(0, 1));
                @(posedge clk0);
                #1;
                check("stall_ready", 32'(rx_ready), 1);
            end
        end
        restart  = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk0);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input bit stall, input bit is_data, input int idx);
        wr_t e;
        send_byte(w[15:8], stall);
        send_byte(w[7:0], stall);
        if (is_data) begin
            e.addr = idx;
            e.data = w;
            e.cyc  = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_image(input string tag, input logic [15:0] n, input logic [15:0] csum, input bit stall);
        logic [15:0] s;
        bit          ok;
        s = '0;
        send_word(n, stall, 1'b0, 0);
        if (int'(n) > CAP) begin
            check({tag, "_len_error"}, 32'(boot_error), 1);
            check({tag, "_len_ready"}, 32'(rx_ready), 0);
            check({tag, "_len_hold"},  32'(core_hold), 1);
            check({tag, "_len_done"},  32'(boot_done), 0);
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                send_word(img[i], stall, 1'b1, i);
                s = s + img[i];
            end
            send_word(csum, stall, 1'b0, 0);
            ok = (s == csum);
            check({tag, "_done"},  32'(boot_done), 32'(ok));
            check({tag, "_hold"},  32'(core_hold), 32'(!ok));
            check({tag, "_error"}, 32'(boot_error), 32'(!ok));
            check({tag, "_ready"}, 32'(rx_ready), 0);
        end
        check({tag, "_pending"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        apply_reset();

        img = '{16'h1234, 16'hABCD, 16'h0001};
        run_image("img3", 16'd3, 16'hBE02, 1'b0);
        do_restart();

        run_image("badsum", 16'd3, 16'h0000, 1'b0);
        repeat (3) @(posedge clk0);
        #1;
        check("err_sticky", 32'(boot_error), 1);
        do_restart();

        run_image("empty", 16'd0, 16'h0000, 1'b0);
        do_restart();

        run_image("toolong", 16'd5, 16'h0000, 1'b0);
        do_restart();

        img = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        run_image("full", 16'd4, 16'hFFFC, 1'b0);
        do_restart();

        img = '{16'h1234, 16'hABCD, 16'h0001};
        run_image("stall", 16'd3, 16'hBE02, 1'b1);
        do_restart();

        send_word(16'd3, 1'b0, 1'b0, 0);
        send_word(16'h1234, 1'b0, 1'b1, 0);
        apply_reset();
        run_image("after_rst", 16'd3, 16'hBE02, 1'b0);
        do_restart();

        img = '{16'h0102, 16'h0304};
        run_image("second", 16'd2, 16'h0406, 1'b1);

        repeat (2) @(posedge clk0);
        #1;
        check("final_pending", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
